// File: rtl/lbist_pkg.sv
// Shared types and helpers for the LBIST session sequencer.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        DONE
    } lbist_state_e;

    // Truncated to the index width at the point of use.
    localparam logic [31:0] NO_FAIL = '1;

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/lbist_vld_pipe.sv
// Delay line aligning applied-pattern {valid, index} with the ORA's registered result.
module lbist_vld_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         tpg_en,
    input  logic [W-1:0] pat_idx,
    output logic         sample_vld,
    output logic [W-1:0] sample_idx
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= tpg_en;
            idx_q[0] <= pat_idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign sample_vld = vld_q[DEPTH-1];
    assign sample_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST session sequencer: seeds/steps the TPG, manages ORA reset and collects results.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 16,
    parameter int unsigned ORA_LAT    = 1,
    parameter int unsigned FAIL_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            ora_res,
    output logic                            tpg_load,
    output logic                            tpg_en,
    output logic                            test_mode,
    output logic                            ora_rst,
    output logic [idx_w(N_PATTERNS)-1:0]    pat_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [FAIL_W-1:0]               fail_count,
    output logic [idx_w(N_PATTERNS)-1:0]    first_fail
);

    localparam int unsigned IW = idx_w(N_PATTERNS);
    localparam int unsigned CW = $clog2(ORA_LAT) + 1;
    localparam logic [IW-1:0] NO_FAIL_IDX = NO_FAIL[IW-1:0];

    lbist_state_e state, state_nxt;
    logic [CW-1:0] flush_cnt, flush_cnt_nxt;
    logic [IW-1:0] pat_idx_nxt, first_fail_nxt;
    logic [FAIL_W-1:0] fail_count_nxt;
    logic tpg_load_nxt, tpg_en_nxt, test_mode_nxt, ora_rst_nxt;
    logic busy_nxt, done_nxt, pass_nxt;
    logic abort_hit;
    logic sample_vld;
    logic [IW-1:0] sample_idx;

    lbist_vld_pipe #(
        .DEPTH (ORA_LAT),
        .W     (IW)
    ) u_vld_pipe (
        .clk        (clk),
        .clr        (rst | abort_hit),
        .tpg_en     (tpg_en),
        .pat_idx    (pat_idx),
        .sample_vld (sample_vld),
        .sample_idx (sample_idx)
    );

    always_comb begin
        state_nxt = state;
        abort_hit = abort && (state == INIT || state == RUN || state == FLUSH);
        unique case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = RUN;
            RUN:     if (pat_idx == IW'(N_PATTERNS - 1)) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == CW'(ORA_LAT - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;

        // Outputs are decoded from the next state so they register in step with it.
        tpg_load_nxt  = 1'b0;
        tpg_en_nxt    = 1'b0;
        test_mode_nxt = 1'b0;
        ora_rst_nxt   = 1'b1;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        unique case (state_nxt)
            INIT: begin
                tpg_load_nxt  = 1'b1;
                test_mode_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
            RUN: begin
                tpg_en_nxt    = 1'b1;
                test_mode_nxt = 1'b1;
                ora_rst_nxt   = 1'b0;
                busy_nxt      = 1'b1;
            end
            FLUSH: begin
                test_mode_nxt = 1'b1;
                ora_rst_nxt   = 1'b0;
                busy_nxt      = 1'b1;
            end
            DONE: begin
                ora_rst_nxt = 1'b0;
                done_nxt    = 1'b1;
            end
            default: ;
        endcase

        pat_idx_nxt = pat_idx;
        if (state == IDLE && state_nxt == INIT) begin
            pat_idx_nxt = '0;
        end else if (state == RUN && state_nxt == RUN) begin
            pat_idx_nxt = pat_idx + 1'b1;
        end

        flush_cnt_nxt = (state == FLUSH) ? flush_cnt + 1'b1 : '0;

        fail_count_nxt = fail_count;
        first_fail_nxt = first_fail;
        pass_nxt       = pass;
        if (state == IDLE && start) begin
            fail_count_nxt = '0;
            first_fail_nxt = NO_FAIL_IDX;
            pass_nxt       = 1'b0;
        end else if (abort_hit) begin
            pass_nxt = 1'b0;
        end else begin
            if (sample_vld && ora_res) begin
                if (fail_count != '1) fail_count_nxt = fail_count + 1'b1;
                if (first_fail == NO_FAIL_IDX) first_fail_nxt = sample_idx;
            end
            // The last sample lands on the FLUSH->DONE edge, so judge on the updated count.
            if (state_nxt == DONE) pass_nxt = (fail_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            tpg_load   <= 1'b0;
            tpg_en     <= 1'b0;
            test_mode  <= 1'b0;
            ora_rst    <= 1'b1;
            pat_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            first_fail <= NO_FAIL_IDX;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            tpg_load   <= tpg_load_nxt;
            tpg_en     <= tpg_en_nxt;
            test_mode  <= test_mode_nxt;
            ora_rst    <= ora_rst_nxt;
            pat_idx    <= pat_idx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail_count <= fail_count_nxt;
            first_fail <= first_fail_nxt;
        end
    end

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: three configurations driven through directed and random sessions.
module tb_lbist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, abort, ora_res;
    logic [2:0] tl, te, tm, orr, bz, dn, ps;
    logic [3:0] pi_a, pi_b, ff_a, ff_b;
    logic [2:0] pi_c, ff_c;
    logic [7:0] fc_a, fc_c;
    logic [1:0] fc_b;
    logic [7:0] o_pi, o_fc, o_ff;
    int sel = 0;
    int n_asserts = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lbist_ctrl #(.N_PATTERNS(8), .ORA_LAT(1), .FAIL_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .ora_res(ora_res[0]),
        .tpg_load(tl[0]), .tpg_en(te[0]), .test_mode(tm[0]), .ora_rst(orr[0]),
        .pat_idx(pi_a), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
        .fail_count(fc_a), .first_fail(ff_a));

    lbist_ctrl #(.N_PATTERNS(8), .ORA_LAT(1), .FAIL_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .ora_res(ora_res[1]),
        .tpg_load(tl[1]), .tpg_en(te[1]), .test_mode(tm[1]), .ora_rst(orr[1]),
        .pat_idx(pi_b), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
        .fail_count(fc_b), .first_fail(ff_b));

    lbist_ctrl #(.N_PATTERNS(4), .ORA_LAT(3), .FAIL_W(8)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .ora_res(ora_res[2]),
        .tpg_load(tl[2]), .tpg_en(te[2]), .test_mode(tm[2]), .ora_rst(orr[2]),
        .pat_idx(pi_c), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
        .fail_count(fc_c), .first_fail(ff_c));

    always_comb begin
        case (sel)
            0:       begin o_pi = 8'(pi_a); o_fc = fc_a;     o_ff = 8'(ff_a); end
            1:       begin o_pi = 8'(pi_b); o_fc = 8'(fc_b); o_ff = 8'(ff_b); end
            default: begin o_pi = 8'(pi_c); o_fc = fc_c;     o_ff = 8'(ff_c); end
        endcase
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (dut %0d): observed %b expected %b", tag, sel, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (dut %0d): observed %0d expected %0d", tag, sel, obs, exp);
        end
    endtask

    function automatic logic noise_bit(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cfg(input int s, output int n, output int lat, output int fw);
        n   = (s == 2) ? 4 : 8;
        lat = (s == 2) ? 3 : 1;
        fw  = (s == 1) ? 2 : 8;
    endtask

    task automatic check_reset(input int s);
        int n, lat, fw, iw;
        cfg(s, n, lat, fw);
        iw = 1;
        while ((1 << (iw - 1)) < n) iw++;
        sel = s;
        #1;
        chk1("rst tpg_load", tl[s], 1'b0);
        chk1("rst tpg_en", te[s], 1'b0);
        chk1("rst test_mode", tm[s], 1'b0);
        chk1("rst ora_rst", orr[s], 1'b1);
        chk1("rst busy", bz[s], 1'b0);
        chk1("rst done", dn[s], 1'b0);
        chk1("rst pass", ps[s], 1'b0);
        chk8("rst pat_idx", o_pi, 8'd0);
        chk8("rst fail_count", o_fc, 8'd0);
        chk8("rst first_fail", o_ff, 8'((1 << iw) - 1));
    endtask

    // Session model: cycle 1 is INIT, RUN occupies cycles 2..n+1, pattern p is judged
    // from ora_res in cycle p+2+lat, FLUSH ends at n+1+lat and done pulses at n+2+lat.
    task automatic run_session(input int s, input logic [15:0] mask, input int noise,
                               input int abort_at, input int rst_at, input bit poke_start);
        int n, lat, fw, iw, kd, ka, kr, kstop, nf, ff, c, p, maxc;
        bit post, act, inrun;
        cfg(s, n, lat, fw);
        iw = 1;
        while ((1 << (iw - 1)) < n) iw++;
        maxc  = (1 << fw) - 1;
        kd    = n + 2 + lat;
        ka    = (abort_at >= 0) ? abort_at + 2 : -1;
        kr    = (rst_at >= 0) ? rst_at + 2 : -1;
        kstop = kd + 1;
        if (ka >= 0) kstop = ka + lat + 3;
        if (kr >= 0) kstop = kr + lat + 3;
        sel = s;
        start[s]   = 1'b1;
        ora_res[s] = noise_bit(noise);
        for (int k = 1; k <= kstop; k++) begin
            @(posedge clk);
            #1;
            start[s] = 1'b0;
            abort[s] = 1'b0;
            rst      = 1'b0;
            post  = (ka >= 0 && k > ka) || (kr >= 0 && k > kr);
            act   = (k >= 1 && k <= kd - 1);
            inrun = (k >= 2 && k <= n + 1);
            nf = 0;
            ff = -1;
            if (!(kr >= 0 && k > kr)) begin
                for (int q = 0; q < n; q++) begin
                    c = q + 2 + lat;
                    if (mask[q] && c < k && (ka < 0 || c < ka)) begin
                        nf++;
                        if (ff < 0) ff = q;
                    end
                end
            end
            if (nf > maxc) nf = maxc;
            chk1("busy", bz[s], !post && act);
            chk1("tpg_load", tl[s], !post && k == 1);
            chk1("tpg_en", te[s], !post && inrun);
            chk1("test_mode", tm[s], !post && act);
            chk1("done", dn[s], !post && k == kd);
            chk1("pass", ps[s], !post && k >= kd && nf == 0);
            if (post || k == 1 || k > kd) chk1("ora_rst", orr[s], 1'b1);
            else if (k < kd)              chk1("ora_rst", orr[s], 1'b0);
            chk8("fail_count", o_fc, 8'(nf));
            chk8("first_fail", o_ff, (ff < 0) ? 8'((1 << iw) - 1) : 8'(ff));
            if (!post && inrun)             chk8("pat_idx", o_pi, 8'(k - 2));
            else if (kr >= 0 && k == kr + 1) chk8("pat_idx", o_pi, 8'd0);

            p = k - 2 - lat;
            if (k == ka)                         ora_res[s] = 1'b0;
            else if (!post && p >= 0 && p < n)   ora_res[s] = mask[p];
            else                                 ora_res[s] = noise_bit(noise);
            if (k == ka) abort[s] = 1'b1;
            if (k == kr) rst = 1'b1;
            if (poke_start && k == 4) start[s] = 1'b1;
            // abort is meaningless in DONE and IDLE; the IDLE one also overlaps the next start.
            if (ka < 0 && kr < 0 && (k == kd || k == kd + 1)) abort[s] = 1'b1;
        end
    endtask

    initial begin
        int s, n, lat, fw, ab;
        logic [15:0] m;
        rst     = 1'b1;
        start   = '0;
        abort   = '0;
        ora_res = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_session(0, 16'h0000, 0, -1, -1, 1'b0);  // clean pass
        run_session(0, 16'h0008, 1, -1, -1, 1'b0);  // one failure at pattern 3, noise outside samples
        run_session(1, 16'h00FF, 2, -1, -1, 1'b0);  // saturating count
        run_session(2, 16'h0008, 2, -1, -1, 1'b0);  // long latency, final-sample failure
        run_session(0, 16'h0006, 2, 4, -1, 1'b0);   // abort at pattern 4
        run_session(0, 16'h0000, 2, -1, -1, 1'b0);  // clean session after abort
        run_session(0, 16'h0021, 2, -1, -1, 1'b1);  // start during RUN ignored
        run_session(0, 16'h0003, 2, -1, 5, 1'b0);   // rst mid-RUN
        run_session(2, 16'h0003, 2, 1, -1, 1'b0);   // abort with results in flight

        for (int r = 0; r < 12; r++) begin
            s = int'($urandom_range(0, 2));
            cfg(s, n, lat, fw);
            m  = 16'($urandom) & 16'((1 << n) - 1);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_session(s, m, 2, ab, -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
